// File: rtl/cov_stream_accum_pkg.sv
// cov_stream_accum_pkg: controller state encoding shared by the scatter-matrix accumulator
package fsm_cov_stream;

    typedef enum logic [2:0] {
        IDLE_CS  = 3'd0,
        ACCUM_CS = 3'd1,
        EMIT_CS  = 3'd2,
        DONE_CS  = 3'd3,
        XXX_CS   = 3'd7
    } state_e;

endpackage

// File: rtl/cov_stream_accum_entry_calc.sv
// cov_entry_calc: one centered scatter entry, Sxx - floor(Sx_a*Sx_b / 2^LOG2_N)
module cov_entry_calc #(
    parameter int LOG2_N   = 7,
    parameter int SX_BITS  = 39,
    parameter int SXX_BITS = 71,
    parameter int COV_BITS = 72
) (
    input  logic signed [SXX_BITS-1:0] sxx_i,
    input  logic signed [SX_BITS-1:0]  sx_a_i,
    input  logic signed [SX_BITS-1:0]  sx_b_i,
    output logic signed [COV_BITS-1:0] entry_o
);

    localparam int W = 2 * SX_BITS + 2;

    logic signed [W-1:0] prod;
    logic signed [W-1:0] diff;

    // wide enough that neither the product nor the difference can wrap before truncation
    always_comb begin
        prod    = W'(sx_a_i) * W'(sx_b_i);
        diff    = W'(sxx_i) - (prod >>> LOG2_N);
        entry_o = COV_BITS'(diff);
    end

endmodule

// File: rtl/cov_stream_accum.sv
// cov_stream_accum: windowed channel-sum / cross-product accumulator emitting the centered scatter matrix; COV_UPPER_ONLY_EN emits only the upper triangle
module cov_stream_accum
    import fsm_cov_stream::*;
#(
    parameter int SIZE_A   = 8,
    parameter int LOG2_N   = 7,
    parameter int N_BITS   = 32,
    parameter int COV_BITS = 2 * N_BITS + LOG2_N + 1,
    localparam int IW      = (SIZE_A > 1) ? $clog2(SIZE_A) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [SIZE_A-1:0][N_BITS-1:0]     in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [COV_BITS-1:0]        out_data,
    output logic [IW-1:0]                     out_row,
    output logic [IW-1:0]                     out_col,
    output logic                              out_last,
    output logic                              f
);

    localparam int SX_BITS  = N_BITS + LOG2_N;
    localparam int SXX_BITS = 2 * N_BITS + LOG2_N;
    localparam int CW       = (LOG2_N > 0) ? LOG2_N : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_N) - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(SIZE_A - 1);
`ifdef COV_UPPER_ONLY_EN
    localparam bit UPPER_ONLY = 1'b1;
`else
    localparam bit UPPER_ONLY = 1'b0;
`endif

    state_e                     state_q;
    logic signed [N_BITS-1:0]   xs [SIZE_A];
    logic signed [SX_BITS-1:0]  sx_q [SIZE_A];
    logic signed [SXX_BITS-1:0] sxx_q [SIZE_A][SIZE_A];
    logic [CW-1:0]              cnt_q;
    logic [IW-1:0]              row_q, col_q, row_d, col_d, lo, hi;
    logic signed [COV_BITS-1:0] entry;
    logic                       in_ready_q, out_valid_q, out_last_q, f_q;
    logic signed [COV_BITS-1:0] out_data_q;
    logic [IW-1:0]              out_row_q, out_col_q;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;
    assign f         = f_q;

    // sample unpacking, upper-triangle lookup for the current entry and next row-major index
    always_comb begin
        for (int i = 0; i < SIZE_A; i++) xs[i] = $signed(in_data[i]);
        lo    = (row_q < col_q) ? row_q : col_q;
        hi    = (row_q < col_q) ? col_q : row_q;
        col_d = (col_q == IDX_LAST) ? (UPPER_ONLY ? row_q + 1'b1 : '0) : col_q + 1'b1;
        row_d = (col_q == IDX_LAST) ? row_q + 1'b1 : row_q;
    end

    cov_entry_calc #(
        .LOG2_N  (LOG2_N),
        .SX_BITS (SX_BITS),
        .SXX_BITS(SXX_BITS),
        .COV_BITS(COV_BITS)
    ) u_calc (
        .sxx_i  (sxx_q[lo][hi]),
        .sx_a_i (sx_q[row_q]),
        .sx_b_i (sx_q[col_q]),
        .entry_o(entry)
    );

    // window controller: accumulate N samples, then stream one registered entry per handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE_CS;
            for (int i = 0; i < SIZE_A; i++) begin
                sx_q[i] <= '0;
                for (int j = 0; j < SIZE_A; j++) sxx_q[i][j] <= '0;
            end
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            f_q         <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            f_q <= 1'b0;
            case (state_q)
                IDLE_CS: if (start) begin
                    state_q    <= ACCUM_CS;
                    in_ready_q <= 1'b1;
                    cnt_q      <= '0;
                    row_q      <= '0;
                    col_q      <= '0;
                    for (int i = 0; i < SIZE_A; i++) begin
                        sx_q[i] <= '0;
                        for (int j = 0; j < SIZE_A; j++) sxx_q[i][j] <= '0;
                    end
                end
                ACCUM_CS: if (in_valid) begin
                    for (int i = 0; i < SIZE_A; i++) begin
                        sx_q[i] <= sx_q[i] + SX_BITS'(xs[i]);
                        for (int j = 0; j < SIZE_A; j++)
                            if (j >= i) sxx_q[i][j] <= sxx_q[i][j] + SXX_BITS'(xs[i]) * SXX_BITS'(xs[j]);
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q    <= EMIT_CS;
                        in_ready_q <= 1'b0;
                    end
                end
                EMIT_CS: if (out_valid_q && out_ready && out_last_q) begin
                    state_q     <= DONE_CS;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    f_q         <= 1'b1;
                end else if (!out_valid_q || out_ready) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= entry;
                    out_row_q   <= row_q;
                    out_col_q   <= col_q;
                    out_last_q  <= (row_q == IDX_LAST) && (col_q == IDX_LAST);
                    row_q       <= row_d;
                    col_q       <= col_d;
                end
                DONE_CS: state_q <= IDLE_CS;
                default: state_q <= IDLE_CS;
            endcase
        end
    end

endmodule

// File: tb/tb_cov_stream_accum.sv
// tb_cov_stream_accum: directed windows against a scoreboard of centered scatter entries
module tb_cov_stream_accum;

    localparam int SA = 2;
    localparam int LN = 2;
    localparam int NB = 8;
    localparam int CB = 2 * NB + LN + 1;
    localparam int NS = 1 << LN;
`ifdef COV_UPPER_ONLY_EN
    localparam bit UPPER = 1'b1;
`else
    localparam bit UPPER = 1'b0;
`endif

    typedef struct {
        int     row;
        int     col;
        longint data;
        bit     last;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    start = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b0;
    logic [SA-1:0][NB-1:0]   in_data = '0;
    logic                    in_ready, out_valid, out_last, f;
    logic signed [CB-1:0]    out_data;
    logic [0:0]              out_row, out_col;

    int    checks = 0;
    int    errors = 0;
    int    smp [NS][SA];
    beat_t sb [$];

    always #5 clk = ~clk;

    cov_stream_accum #(.SIZE_A(SA), .LOG2_N(LN), .N_BITS(NB)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .f(f)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reference: direct sums over the stored window, floor division by N
    task automatic model_push();
        longint sx [SA];
        longint sxx [SA][SA];
        longint p, q;
        beat_t  b;
        for (int i = 0; i < SA; i++) begin
            sx[i] = 0;
            for (int j = 0; j < SA; j++) sxx[i][j] = 0;
        end
        for (int k = 0; k < NS; k++)
            for (int i = 0; i < SA; i++) begin
                sx[i] += smp[k][i];
                for (int j = 0; j < SA; j++) sxx[i][j] += longint'(smp[k][i]) * smp[k][j];
            end
        for (int i = 0; i < SA; i++)
            for (int j = 0; j < SA; j++)
                if (!UPPER || j >= i) begin
                    p = sx[i] * sx[j];
                    q = p / NS;
                    if (p % NS != 0 && p < 0) q = q - 1;
                    b.row  = i;
                    b.col  = j;
                    b.data = sxx[i][j] - q;
                    b.last = (i == SA - 1) && (j == SA - 1);
                    sb.push_back(b);
                end
    endtask

    task automatic send_window(input int bubble_at);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (k == bubble_at) begin
                in_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
            chk("accum_in_ready", in_ready, 1);
            in_valid = 1'b1;
            for (int c = 0; c < SA; c++) in_data[c] = NB'(smp[k][c]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("emit_in_ready", in_ready, 0);
        chk("emit_first_gap", out_valid, 0);
        model_push();
    endtask

    task automatic drain(input bit bp, input bit start_poke);
        int    c = 0;
        bit    done = 1'b0;
        bit    held = 1'b0;
        beat_t e;
        logic signed [CB-1:0] hd;
        logic [0:0] hr, hc;
        logic hl;
        while (!done && c < 100) begin
            @(negedge clk);
            if (c == 0) chk("first_valid", out_valid, 1);
            if (held) begin
                chk("hold_data", out_data, hd);
                chk("hold_row", out_row, hr);
                chk("hold_col", out_col, hc);
                chk("hold_last", out_last, hl);
                held = 1'b0;
            end
            start = start_poke && (c < 3);
            out_ready = !bp || (c % 4 == 0) || (c % 4 == 3);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("extra_beat", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("beat_row", out_row, e.row);
                    chk("beat_col", out_col, e.col);
                    chk("beat_data", out_data, e.data);
                    chk("beat_last", out_last, e.last);
                    done = out_last;
                end
            end else if (out_valid) begin
                held = 1'b1;
                hd = out_data;
                hr = out_row;
                hc = out_col;
                hl = out_last;
            end
            c++;
        end
        start = 1'b0;
        if (!done) chk("drain_timeout", 0, 1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("f_pulse", f, 1);
        chk("done_valid", out_valid, 0);
        @(negedge clk);
        chk("f_clear", f, 0);
        chk("idle_in_ready", in_ready, 0);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_f", f, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        rst = 1'b1;

        smp = '{'{1, 2}, '{2, 4}, '{3, 6}, '{4, 8}};
        send_window(-1);
        drain(1'b0, 1'b0);

        smp = '{'{-1, 3}, '{-1, -5}, '{-1, 7}, '{-1, 0}};
        send_window(-1);
        drain(1'b0, 1'b0);

        smp = '{'{-128, -128}, '{-128, -128}, '{-128, -128}, '{-128, -128}};
        send_window(-1);
        drain(1'b0, 1'b0);

        smp = '{'{1, 0}, '{0, 0}, '{0, 0}, '{0, -3}};
        send_window(-1);
        drain(1'b0, 1'b0);

        smp = '{'{1, 2}, '{2, 4}, '{3, 6}, '{4, 8}};
        send_window(2);
        drain(1'b1, 1'b1);

        smp = '{'{100, -90}, '{-77, 55}, '{0, 0}, '{0, 0}};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < SA; c++) in_data[c] = NB'(smp[0][c]);
        @(negedge clk);
        for (int c = 0; c < SA; c++) in_data[c] = NB'(smp[1][c]);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_f", f, 0);
        @(negedge clk);
        rst = 1'b1;

        smp = '{'{5, -7}, '{-3, 2}, '{9, 1}, '{-6, 4}};
        send_window(-1);
        drain(1'b1, 1'b0);

        for (int k = 0; k < NS; k++)
            for (int c = 0; c < SA; c++) smp[k][c] = int'($urandom_range(0, 255)) - 128;
        send_window(1);
        drain(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
